// File: rtl/rpsc_fault_card.sv
// rpsc_fault_card: N-channel interlock fault card.
// Each channel has a contact synchroniser, a debounce filter, a latching or
// auto-reset trip latch and an alarm-lamp state machine. A card-wide
// first-out register makes the first tripping lamp flash until acknowledged.
// Internal state updates on one edge; the visible outputs are registered
// from that state one cycle later. LA_Test is ORed in after the lamp register.
// The reset input is assumed to be released synchronously to clk by the
// card-level reset generator.
module rpsc_fault_card #(
    parameter int              N_CH            = 8,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter logic [N_CH-1:0] LATCH_MASK      = '1,
    parameter int              FLASH_HALF      = 25_000_000,
    localparam int             ID_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            LA_Test,
    input  logic            ack,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] out,
    output logic [N_CH-1:0] LA,
    output logic            trip_any,
    output logic            first_valid,
    output logic [ID_W-1:0] first_id
);

    localparam int              FL_W    = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [15:0]     DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_HALF - 1);

    typedef enum logic [1:0] {
        LAMP_OFF   = 2'd0,
        LAMP_ALARM = 2'd1,
        LAMP_ACKED = 2'd2
    } lamp_state_t;

    // Front end and per-channel state
    logic [N_CH-1:0] r_meta;
    logic [N_CH-1:0] r_s;
    logic [N_CH-1:0] r_d;
    logic [N_CH-1:0] r_t;
    logic [15:0]     r_cnt  [N_CH];
    lamp_state_t     r_lamp [N_CH];

    // Card-wide first-out and flash timebase
    logic            r_fv;
    logic [ID_W-1:0] r_fid;
    logic [FL_W-1:0] r_flash_cnt;
    logic            r_phase;

    // Output registers
    logic [N_CH-1:0] r_out;
    logic [N_CH-1:0] r_la;
    logic            r_trip_any;
    logic            r_first_valid;
    logic [ID_W-1:0] r_first_id;

    // Combinational next-state terms
    logic [N_CH-1:0] w_flip;
    logic [N_CH-1:0] w_trip_evt;
    logic [N_CH-1:0] w_t_next;
    logic [N_CH-1:0] w_lamp;
    logic [ID_W-1:0] w_low_id;
    logic            w_capture;

    // Debounce decision: flip when the synchronised input has disagreed for the full window
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_flip = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_flip[i] = (r_s[i] != r_d[i]) && (r_cnt[i] == DB_LAST);
        end
    end

    // A trip event is the debounced state falling 1 -> 0 on this edge
    assign w_trip_evt = w_flip & r_d;

    // Trip latch next state: trip sets (latching channels only) over ack, ack clears only healthy channels
    always_comb begin
        w_t_next = r_t;
        for (int i = 0; i < N_CH; i++) begin
            if (w_trip_evt[i] && LATCH_MASK[i]) begin
                w_t_next[i] = 1'b1;
            end else if (ack && r_d[i]) begin
                w_t_next[i] = 1'b0;
            end
        end
    end

    // Lowest-indexed channel tripping in this cycle
    always_comb begin
        w_low_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (w_trip_evt[i]) begin
                w_low_id = ID_W'(i);
            end
        end
    end

    // Capture a first-out when none is held, or when ack releases the current one this cycle
    assign w_capture = (|w_trip_evt) && !(r_fv && !ack);

    // Two-flop synchroniser on the asynchronous field contacts
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_meta <= '0;
            r_s    <= '0;
        end else begin
            r_meta <= in;
            r_s    <= r_meta;
        end
    end

    // Debounce counters and debounced state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: these arrays are flops, not RAM, so they are reset element by element.
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
            r_d <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (r_s[i] == r_d[i] || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 16'd1;
                end
            end
            r_d <= r_d ^ w_flip;
        end
    end

    // Trip latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t <= '0;
        end else begin
            r_t <= w_t_next;
        end
    end

    // Lamp state machine per channel: trip event always wins, ack moves ALARM on
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                r_lamp[i] <= LAMP_OFF;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_trip_evt[i]) begin
                    r_lamp[i] <= LAMP_ALARM;
                end else begin
                    case (r_lamp[i])
                        LAMP_OFF: r_lamp[i] <= LAMP_OFF;
                        LAMP_ALARM: begin
                            if (ack) begin
                                r_lamp[i] <= (r_d[i] && !w_t_next[i]) ? LAMP_OFF : LAMP_ACKED;
                            end
                        end
                        LAMP_ACKED: begin
                            if (r_d[i] && !w_t_next[i]) begin
                                r_lamp[i] <= LAMP_OFF;
                            end
                        end
                        default: r_lamp[i] <= LAMP_OFF;
                    endcase
                end
            end
        end
    end

    // First-out register: later trips never overwrite a held first-out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fv  <= 1'b0;
            r_fid <= '0;
        end else if (w_capture) begin
            r_fv  <= 1'b1;
            r_fid <= w_low_id;
        end else if (ack) begin
            r_fv  <= 1'b0;
        end
    end

    // Free-running flash phase, toggling every FLASH_HALF cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flash_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_flash_cnt == FL_LAST) begin
            r_flash_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_flash_cnt <= r_flash_cnt + FL_W'(1);
        end
    end

    // Lamp decode: the first-out channel in ALARM follows the flash phase
    always_comb begin
        w_lamp = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (r_lamp[i])
                LAMP_ALARM: w_lamp[i] = (r_fv && r_fid == ID_W'(i)) ? r_phase : 1'b1;
                LAMP_ACKED: w_lamp[i] = 1'b1;
                default:    w_lamp[i] = 1'b0;
            endcase
        end
    end

    // Output registers, one cycle behind the internal state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out         <= '0;
            r_la          <= '0;
            r_trip_any    <= 1'b1;
            r_first_valid <= 1'b0;
            r_first_id    <= '0;
        end else begin
            r_out         <= r_d & ~r_t;
            r_la          <= w_lamp;
            r_trip_any    <= ~&(r_d & ~r_t);
            r_first_valid <= r_fv;
            r_first_id    <= r_fid;
        end
    end

    assign out         = r_out;
    assign LA          = r_la | {N_CH{LA_Test}};
    assign trip_any    = r_trip_any;
    assign first_valid = r_first_valid;
    assign first_id    = r_first_id;

endmodule

// File: doc/rpsc_fault_card.md
# rpsc_fault_card

Parametrised interlock fault card: N channels, each with input synchronisation, debounce, per-channel latching/auto-reset trip mode, and an alarm-lamp state machine with first-out flashing, acknowledge and lamp test. It generalises the fixed eight-channel RPSC card into one block that every RPSC card position instantiates. Downstream logic ANDs the `out` vector into the permissive chain, and `LA` drives the front-panel lamps.

## Interface
- N_CH, 8, number of channels (1..32)
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to change the debounced state (1..65535)
- LATCH_MASK, all ones (N_CH bits), bit i = 1: channel i latching trip; 0: auto-reset trip
- FLASH_HALF, 25_000_000, clk cycles per half-period of the first-out flash (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- LA_Test  in  1  lamp test; forces every `LA` bit to 1 while high
- ack  in  1  synchronous acknowledge/clear, acted on in every cycle it is high
- in  in  N_CH  field contacts, asynchronous; 1 = healthy, 0 = fault
- out  out  N_CH  permissive; 1 = healthy, 0 = tripped
- LA  out  N_CH  lamp drive; 1 = lamp on
- trip_any  out  1  OR of all channels not permissive
- first_valid  out  1  a first-out channel is captured
- first_id  out  $clog2(N_CH) (min 1)  index of the first-out channel

## Operation
- Per channel: 2-flop synchroniser → `s`. Debounced state `d` flips when `s != d` for DEBOUNCE_CYCLES consecutive cycles. The counter clears whenever `s == d`.
- Trip event: `d` transitions 1→0. The trip latch `t` is set on a trip event, for latching channels only.
- `out[i] = d & ~t`, registered.
- `ack`: clears `t[i]` only where `d[i] = 1` in that cycle. A channel still faulted keeps `t`.
- Lamp FSM per channel:
  - OFF → ALARM on trip event.
  - ALARM → ACKED on `ack`. In the same cycle, go straight to OFF if the channel is clear: `d = 1` and `t` is clear after the ack.
  - ACKED → OFF when `d = 1` and `t = 0`.
  - Any state → ALARM on a new trip event. A trip event has priority over `ack` in the same cycle.
- Lamp output:
  - OFF: 0.
  - ALARM: 1 steady. If the channel is the first-out, it flashes from a free-running phase bit toggling every FLASH_HALF cycles.
  - ACKED: 1.
  - `LA_Test = 1` forces 1 without altering any state.
- First-out:
  - On any trip event while `first_valid = 0`, capture `first_id` as the lowest-indexed channel tripping in that cycle, and set `first_valid`.
  - `ack` clears `first_valid`. A trip event in the same cycle as `ack` is captured as the new first-out. Later trips never overwrite the first-out.
- Reset (async assert, sync release):
  - `d = 0`, `t = 0`, counters 0, all lamps OFF, `first_valid = 0`, `first_id = 0`, flash phase 0.
  - Outputs: `out = 0`, `LA = 0`, `trip_any = 1`, `first_valid = 0`, `first_id = 0`.
  - The reset state is not a trip event. Healthy inputs re-qualify without raising an alarm.
- Reset mid-debounce or mid-flash discards all progress.

## Timing
- `in` change stable from edge k:
  - `s` changes at edge k+2.
  - `d` changes at edge k+2+DEBOUNCE_CYCLES.
  - `out`, `LA`, `trip_any`, `first_*` update at edge k+3+DEBOUNCE_CYCLES.
- Glitch rule: a pulse of `s` shorter than DEBOUNCE_CYCLES cycles produces no change.
- `ack` at edge j: `out`, `LA`, `first_valid` reflect it at edge j+1.
- `LA_Test` acts combinationally on `LA` (single OR gate after the lamp register).
- `trip_any` is a registered OR, updating in the same cycle as `out`.

## Test plan
- Release reset with `in` all 1, DEBOUNCE_CYCLES = 4 → `out = 0xFF` exactly 7 cycles after release; `LA = 0`; `first_valid = 0`; no alarm.
- Channel 3 `in` drops to 0 for 3 cycles, then 1 (DEBOUNCE_CYCLES = 4) → no change on any output.
- Channels 5 and 2 fault in the same cycle, both latching, then `in` returns healthy:
  - Before ack: `first_id = 2`; `LA[2]` flashes with period 2·FLASH_HALF; `LA[5] = 1` steady; `out[2]` and `out[5]` stay 0.
  - After `ack`: `out = 0xFF`; `LA = 0`; `first_valid = 0`.
- Auto-reset channel 1 faults, then recovers:
  - `out[1]` returns to 1 after debounce.
  - `LA[1]` stays flashing until `ack`, then goes to 0 one cycle later.
- Latching channel 4 still faulted when `ack` is pulsed → `out[4] = 0`, `LA[4] = 1` steady (ACKED). When the input heals: `out[4]` stays 0 and `LA[4]` stays 1 until a second `ack`.
- `LA_Test` high during ALARM/ACKED/OFF states → `LA = all ones`. On release, the prior lamp states resume unchanged.
- Trip on channel 6 in the same cycle as `ack` → channel 6 ends in ALARM with `first_id = 6`.
- Reset asserted mid-flash → all outputs take their reset values immediately.
